// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters.
// Optional done-timeout path is enabled by defining ALU_ARB_TIMEOUT_EN.
module alu_arbiter #(
    parameter int TO_CYC = 63
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic [1:0] op0,
    input  logic [1:0] op1,
    input  logic [3:0] a0,
    input  logic [3:0] b0,
    input  logic [3:0] a1,
    input  logic [3:0] b1,
    input  logic       sel0,
    input  logic       sel1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       rsp_valid0,
    output logic       rsp_valid1,
    output logic [5:0] rsp_resul,
    output logic       rsp_cout,
    output logic       rsp_signo,
    output logic       rsp_err,
    output logic       alu_init,
    output logic [1:0] alu_op,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic       alu_sel,
    input  logic       alu_done,
    input  logic [5:0] alu_resul,
    input  logic       alu_c_out,
    input  logic       alu_signo
);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

    state_t     state_q, state_d;
    logic       owner_q, owner_d;
    logic       last_q, last_d;
    logic [1:0] op_q, op_d;
    logic [3:0] a_q, a_d;
    logic [3:0] b_q, b_d;
    logic       sel_q, sel_d;
    logic       done_q;
    logic [5:0] res_q, res_d;
    logic       cout_q, cout_d;
    logic       signo_q, signo_d;
    logic       done_rise;
    logic       win;
    logic       busy;
    logic [1:0] gnt_v, rsp_v;

    if (TO_CYC < 1) begin : g_to_cyc_check
        $error("TO_CYC must be at least 1");
    end

`ifdef ALU_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TO_CYC + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          to_hit;
`endif

    // Only a fresh 0->1 transition counts; a level left over from before launch is ignored.
    assign done_rise = alu_done & ~done_q;
    // On contention the requester not served last wins; otherwise the lone requester wins.
    assign win       = (req0 & req1) ? ~last_q : ~req0;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        sel_d   = sel_q;
        res_d   = res_q;
        cout_d  = cout_q;
        signo_d = signo_q;
`ifdef ALU_ARB_TIMEOUT_EN
        err_d   = err_q;
        cnt_d   = '0;
        to_hit  = (cnt_q == CW'(TO_CYC - 1));
`endif
        case (state_q)
            IDLE: begin
                if (req0 | req1) begin
                    owner_d = win;
                    op_d    = win ? op1  : op0;
                    a_d     = win ? a1   : a0;
                    b_d     = win ? b1   : b0;
                    sel_d   = win ? sel1 : sel0;
                    state_d = LAUNCH;
                end
            end
            LAUNCH: state_d = WAIT;
            WAIT: begin
                if (done_rise) begin
                    res_d   = alu_resul;
                    cout_d  = alu_c_out;
                    signo_d = alu_signo;
                    last_d  = owner_q;
                    state_d = RESP;
`ifdef ALU_ARB_TIMEOUT_EN
                    err_d   = 1'b0;
                end else if (to_hit) begin
                    res_d   = '0;
                    cout_d  = 1'b0;
                    signo_d = 1'b0;
                    err_d   = 1'b1;
                    last_d  = owner_q;
                    state_d = RESP;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
`endif
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sel_q   <= 1'b0;
            done_q  <= 1'b0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            signo_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sel_q   <= sel_d;
            done_q  <= alu_done;
            res_q   <= res_d;
            cout_q  <= cout_d;
            signo_q <= signo_d;
        end
    end

`ifdef ALU_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

    for (genvar gi = 0; gi < 2; gi++) begin : g_req
        assign gnt_v[gi] = (state_q == LAUNCH) && (owner_q == 1'(gi));
        assign rsp_v[gi] = (state_q == RESP) && (owner_q == 1'(gi));
    end

    assign busy       = (state_q != IDLE);
    assign gnt0       = gnt_v[0];
    assign gnt1       = gnt_v[1];
    assign rsp_valid0 = rsp_v[0];
    assign rsp_valid1 = rsp_v[1];
    assign alu_init   = (state_q == LAUNCH);
    assign alu_op     = busy ? op_q  : '0;
    assign alu_a      = busy ? a_q   : '0;
    assign alu_b      = busy ? b_q   : '0;
    assign alu_sel    = busy ? sel_q : 1'b0;
    assign rsp_resul  = res_q;
    assign rsp_cout   = cout_q;
    assign rsp_signo  = signo_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: transaction-level reference model checked every cycle,
// a scripted ALU responder, and directed scenarios with hand-computed expectations.
module tb_alu_arbiter;
    localparam int TO_CYC = 12;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 0, req1 = 0;
    logic [1:0] op0 = 0, op1 = 0;
    logic [3:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
    logic       sel0 = 0, sel1 = 0;
    logic       gnt0, gnt1, rsp_valid0, rsp_valid1;
    logic [5:0] rsp_resul;
    logic       rsp_cout, rsp_signo, rsp_err;
    logic       alu_init;
    logic [1:0] alu_op;
    logic [3:0] alu_a, alu_b;
    logic       alu_sel;
    logic       alu_done = 0;
    logic [5:0] alu_resul = 0;
    logic       alu_c_out = 0, alu_signo = 0;

    alu_arbiter #(.TO_CYC(TO_CYC)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1), .sel0(sel0), .sel1(sel1),
        .gnt0(gnt0), .gnt1(gnt1), .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
        .rsp_resul(rsp_resul), .rsp_cout(rsp_cout), .rsp_signo(rsp_signo), .rsp_err(rsp_err),
        .alu_init(alu_init), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_done(alu_done), .alu_resul(alu_resul), .alu_c_out(alu_c_out), .alu_signo(alu_signo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int n_rv0 = 0, n_rv1 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ALU stand-in: mode 0 pulses done alu_dly cycles after init, mode 1 holds done
    // high through launch then drops and re-raises it, mode 2 never answers.
    int         alu_mode = 0;
    int         alu_dly = 2;
    bit         armed = 0;
    int         acnt = 0;
    logic [5:0] pend_res;
    logic       pend_c, pend_s;
    logic [5:0] sum6;

    always @(negedge clk) begin
        #1;
        if (rst) begin
            armed = 0;
            alu_done = 0;
            alu_resul = 0;
            alu_c_out = 0;
            alu_signo = 0;
        end else if (alu_init) begin
            case (alu_op)
                2'd0: sum6 = {2'b00, alu_a} + {2'b00, alu_b};
                2'd1: sum6 = {2'b00, alu_a} - {2'b00, alu_b};
                2'd2: sum6 = {2'b00, alu_a & alu_b};
                default: sum6 = {2'b00, alu_a | alu_b};
            endcase
            pend_res = sum6;
            pend_c = sum6[4];
            pend_s = alu_sel;
            armed = 1;
            acnt = (alu_mode == 1) ? 7 : alu_dly;
        end else if (armed) begin
            acnt--;
            if (alu_mode == 1 && acnt == 5) alu_done = 0;
            if (acnt == 0 && alu_mode != 2) begin
                alu_done = 1;
                alu_resul = pend_res;
                alu_c_out = pend_c;
                alu_signo = pend_s;
                armed = 0;
            end
        end else begin
            alu_done = (alu_mode == 1);
            alu_resul = 0;
            alu_c_out = 0;
            alu_signo = 0;
        end
    end

    // Reference model: one outstanding transaction, step 0 free, 1 granted,
    // 2 computing, 3 answering; answers are remembered until the next one.
    int         m_step = 0, m_wait = 0;
    int         m_own = 0, m_last = 1;
    logic [1:0] m_op = 0;
    logic [3:0] m_a = 0, m_b = 0;
    logic       m_sel = 0, m_prev_done = 0;
    logic [5:0] m_res = 0;
    logic       m_c = 0, m_s = 0, m_err = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_step = 0; m_wait = 0; m_last = 1; m_prev_done = 0;
            m_res = 0; m_c = 0; m_s = 0; m_err = 0;
        end else begin
            case (m_step)
                0: if (req0 || req1) begin
                    if (req0 && req1) m_own = (m_last == 1) ? 0 : 1;
                    else m_own = req0 ? 0 : 1;
                    m_op = m_own ? op1 : op0;
                    m_a = m_own ? a1 : a0;
                    m_b = m_own ? b1 : b0;
                    m_sel = m_own ? sel1 : sel0;
                    m_step = 1;
                end
                1: begin m_step = 2; m_wait = 0; end
                2: begin
                    if (alu_done && !m_prev_done) begin
                        m_res = alu_resul; m_c = alu_c_out; m_s = alu_signo; m_err = 0;
                        m_last = m_own; m_step = 3;
                    end
`ifdef ALU_ARB_TIMEOUT_EN
                    else if (m_wait == TO_CYC - 1) begin
                        m_res = 0; m_c = 0; m_s = 0; m_err = 1;
                        m_last = m_own; m_step = 3;
                    end
`endif
                    else m_wait++;
                end
                default: m_step = 0;
            endcase
            m_prev_done = alu_done;
        end
    end

    always @(posedge clk) begin
        #2;
        chk("gnt0", gnt0, m_step == 1 && m_own == 0);
        chk("gnt1", gnt1, m_step == 1 && m_own == 1);
        chk("rsp_valid0", rsp_valid0, m_step == 3 && m_own == 0);
        chk("rsp_valid1", rsp_valid1, m_step == 3 && m_own == 1);
        chk("alu_init", alu_init, m_step == 1);
        chk("alu_op", alu_op, (m_step != 0) ? m_op : 2'd0);
        chk("alu_a", alu_a, (m_step != 0) ? m_a : 4'd0);
        chk("alu_b", alu_b, (m_step != 0) ? m_b : 4'd0);
        chk("alu_sel", alu_sel, (m_step != 0) ? m_sel : 1'b0);
        chk("rsp_resul", rsp_resul, m_res);
        chk("rsp_cout", rsp_cout, m_c);
        chk("rsp_signo", rsp_signo, m_s);
        chk("rsp_err", rsp_err, m_err);
        if (rsp_valid0) n_rv0++;
        if (rsp_valid1) n_rv1++;
    end

    function automatic logic pick(input int which);
        case (which)
            0: return gnt0;
            1: return gnt1;
            2: return rsp_valid0;
            default: return rsp_valid1;
        endcase
    endfunction

    // Waits (bounded) for gnt0/gnt1/rsp_valid0/rsp_valid1 and returns the cycle seen.
    task automatic wait_sig(input int which, input int maxc, input string nm, output int at);
        at = -1;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (pick(which)) begin
                at = cyc;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL %s: event not seen within %0d cycles (cycle %0d)", nm, maxc, cyc);
    endtask

    task automatic wait_any(input int maxc, output int who);
        who = -1;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (rsp_valid0 || rsp_valid1) begin
                who = rsp_valid1 ? 1 : 0;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL wait_any: no rsp_valid within %0d cycles (cycle %0d)", maxc, cyc);
    endtask

    task automatic set_req(input int r, input logic [1:0] op, input logic [3:0] a,
                           input logic [3:0] b, input logic sel);
        if (r == 0) begin req0 = 1; op0 = op; a0 = a; b0 = b; sel0 = sel; end
        else begin req1 = 1; op1 = op; a1 = a; b1 = b; sel1 = sel; end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1; req0 = 0; req1 = 0;
        @(negedge clk);
        rst = 0;
    endtask

    int tg, tr, t_req, who, base0, base1;
    int exp_own[3] = '{0, 1, 0};
    int exp_res[3] = '{3, 11, 3};

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_gnt0", gnt0, 0);
        chk("rst_alu_init", alu_init, 0);
        chk("rst_rsp_resul", rsp_resul, 0);
        chk("rst_alu_a", alu_a, 0);
        rst = 0;
        @(negedge clk);

        // Single request, done 10 cycles after init
        alu_dly = 10;
        set_req(0, 2'd0, 4'd3, 4'd4, 1'b0);
        t_req = cyc;
        wait_sig(0, 5, "t1_gnt0", tg);
        chk("t1_gnt_latency", tg, t_req + 1);
        chk("t1_alu_a", alu_a, 3);
        chk("t1_alu_b", alu_b, 4);
        wait_sig(2, 30, "t1_rsp0", tr);
        chk("t1_rsp_latency", tr, tg + 11);
        chk("t1_rsp_resul", rsp_resul, 7);
        chk("t1_rsp_err", rsp_err, 0);
        req0 = 0;

        // Request dropped right after its grant still gets answered
        alu_dly = 4;
        set_req(1, 2'd0, 4'd9, 4'd5, 1'b1);
        wait_sig(1, 5, "t2_gnt1", tg);
        req1 = 0;
        wait_sig(3, 20, "t2_rsp1", tr);
        chk("t2_rsp_latency", tr, tg + 5);
        chk("t2_rsp_resul", rsp_resul, 14);
        chk("t2_rsp_signo", rsp_signo, 1);

        // Contention after reset: both held, owners must alternate 0,1,0
        do_reset();
        alu_dly = 2;
        set_req(0, 2'd0, 4'd1, 4'd2, 1'b0);
        set_req(1, 2'd0, 4'd5, 4'd6, 1'b0);
        for (int k = 0; k < 3; k++) begin
            wait_any(20, who);
            chk("t3_owner", who, exp_own[k]);
            chk("t3_resul", rsp_resul, exp_res[k]);
        end
        req0 = 0; req1 = 0;
        @(negedge clk);

        // Stale done held high through launch
        alu_mode = 1;
        @(negedge clk);
        base0 = n_rv0;
        set_req(0, 2'd0, 4'd2, 4'd2, 1'b0);
        wait_sig(0, 5, "t4_gnt0", tg);
        wait_sig(2, 30, "t4_rsp0", tr);
        chk("t4_rsp_after_reraise", tr, tg + 8);
        chk("t4_rsp_resul", rsp_resul, 4);
        req0 = 0;
        alu_mode = 0;
        repeat (6) @(negedge clk);
        chk("t4_single_rsp", n_rv0 - base0, 1);

        // Reset three cycles after gnt1 abandons the operation
        alu_dly = 20;
        set_req(1, 2'd0, 4'd7, 4'd7, 1'b1);
        wait_sig(1, 5, "t5_gnt1", tg);
        repeat (3) @(negedge clk);
        rst = 1; req1 = 0;
        base1 = n_rv1;
        @(negedge clk);
        rst = 0;
        chk("t5_rsp_resul_zero", rsp_resul, 0);
        chk("t5_alu_a_zero", alu_a, 0);
        chk("t5_alu_init_zero", alu_init, 0);
        chk("t5_rsp_signo_zero", rsp_signo, 0);
        repeat (25) @(negedge clk);
        chk("t5_no_rsp1", n_rv1 - base1, 0);
        alu_dly = 2;
        set_req(1, 2'd0, 4'd1, 4'd1, 1'b0);
        wait_sig(1, 5, "t5b_gnt1", tg);
        wait_sig(3, 10, "t5b_rsp1", tr);
        chk("t5b_rsp_resul", rsp_resul, 2);
        req1 = 0;

`ifdef ALU_ARB_TIMEOUT_EN
        // ALU never answers: timeout response after TO_CYC cycles in WAIT
        alu_mode = 2;
        set_req(0, 2'd0, 4'd5, 4'd5, 1'b0);
        wait_sig(0, 5, "t6_gnt0", tg);
        wait_sig(2, TO_CYC + 10, "t6_rsp0", tr);
        chk("t6_timeout_cycle", tr, tg + 1 + TO_CYC);
        chk("t6_rsp_err", rsp_err, 1);
        chk("t6_rsp_resul", rsp_resul, 0);
        req0 = 0;
        alu_mode = 0;
        set_req(1, 2'd0, 4'd1, 4'd2, 1'b0);
        wait_sig(3, 10, "t6b_rsp1", tr);
        chk("t6b_rsp_err", rsp_err, 0);
        chk("t6b_rsp_resul", rsp_resul, 3);
        req1 = 0;
`else
        // ALU never answers: the block must keep waiting
        alu_mode = 2;
        base0 = n_rv0;
        set_req(0, 2'd0, 4'd5, 4'd5, 1'b0);
        wait_sig(0, 5, "t6_gnt0", tg);
        repeat (3 * TO_CYC) @(negedge clk);
        chk("t6_still_waiting", n_rv0 - base0, 0);
        chk("t6_rsp_err", rsp_err, 0);
        chk("t6_alu_a_held", alu_a, 5);
        alu_mode = 0;
        do_reset();
`endif

        // Sweep a, b over 0..7 alternating requesters
        alu_dly = 2;
        @(negedge clk);
        for (int i = 0; i < 64; i++) begin
            set_req(i & 1, 2'd0, 4'(i >> 3), 4'(i & 7), 1'b1);
            wait_sig(i & 1, 5, "t7_gnt", tg);
            wait_sig(2 + (i & 1), 10, "t7_rsp", tr);
            chk("t7_sum", rsp_resul, (i >> 3) + (i & 7));
            if ((i & 1) == 0) req0 = 0; else req1 = 0;
        end
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
